// File: rtl/cond_unit.sv
// cond_unit: condition-evaluation stage between decode and the datapath strobes.
//
// Holds the architectural NZCV flags register, evaluates the 4-bit ARM condition field of each
// accepted instruction against the stored flags, and emits the gated write/branch strobes one
// cycle after issue.
//
// Optional feature macro: COND_STATS_EN
//   When defined, two saturating counters (exec_cnt_o, squash_cnt_o) are added that count
//   accepted instructions whose condition passed / failed. An illegal condition counts as a
//   squash. When undefined, the counters and their ports are absent.
//
// Parameters
//   CNT_W        width of the optional statistics counters
//
// Ports
//   clk          clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   stall_i      hold: no flag update, output stage frozen, inputs ignored
//   in_valid_i   instruction presented this cycle
//   in_ready_o   combinational ~stall_i
//   cond_i       condition field (ARM encoding)
//   alu_flags_i  {N,Z,C,V} produced by the ALU for this instruction
//   flag_w_i     [1]: update N,Z  [0]: update C,V
//   reg_w_i      requested register write
//   mem_w_i      requested memory write
//   pc_src_i     requested PC redirect
//   out_valid_o  registered: an instruction was accepted last cycle
//   cond_ex_o    registered: its condition passed
//   reg_write_o  registered: reg_w_i & cond_ex
//   mem_write_o  registered: mem_w_i & cond_ex
//   pc_src_o     registered: pc_src_i & cond_ex
//   illegal_o    registered: cond_i == 4'b1111
//   flags_o      current stored {N,Z,C,V}
//   exec_cnt_o   (COND_STATS_EN) saturating count of executed instructions
//   squash_cnt_o (COND_STATS_EN) saturating count of squashed instructions

module cond_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       cond_i,
  input  logic [3:0]       alu_flags_i,
  input  logic [1:0]       flag_w_i,
  input  logic             reg_w_i,
  input  logic             mem_w_i,
  input  logic             pc_src_i,
  output logic             out_valid_o,
  output logic             cond_ex_o,
  output logic             reg_write_o,
  output logic             mem_write_o,
  output logic             pc_src_o,
  output logic             illegal_o,
  output logic [3:0]       flags_o
`ifdef COND_STATS_EN
  ,
  output logic [CNT_W-1:0] exec_cnt_o,
  output logic [CNT_W-1:0] squash_cnt_o
`endif
);

  // Condition-field encodings.
  typedef enum logic [3:0] {
    CondEq = 4'h0,
    CondNe = 4'h1,
    CondCs = 4'h2,
    CondCc = 4'h3,
    CondMi = 4'h4,
    CondPl = 4'h5,
    CondVs = 4'h6,
    CondVc = 4'h7,
    CondHi = 4'h8,
    CondLs = 4'h9,
    CondGe = 4'hA,
    CondLt = 4'hB,
    CondGt = 4'hC,
    CondLe = 4'hD,
    CondAl = 4'hE,
    CondNv = 4'hF
  } cond_e;

  logic [3:0] flags_q, flags_d;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       accept;
  logic       cond_pass;
  logic       cond_illegal;
  logic       exec;

  logic out_valid_q, out_valid_d;
  logic cond_ex_q,   cond_ex_d;
  logic reg_write_q, reg_write_d;
  logic mem_write_q, mem_write_d;
  logic pc_src_q,    pc_src_d;
  logic illegal_q,   illegal_d;

  assign in_ready_o = ~stall_i;
  assign accept     = in_valid_i & ~stall_i;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Evaluated against the stored flags only; the ALU flags of this instruction never feed back
  // into its own condition.
  always_comb begin
    cond_pass    = 1'b0;
    cond_illegal = 1'b0;
    unique case (cond_e'(cond_i))
      CondEq: cond_pass = flag_z;
      CondNe: cond_pass = ~flag_z;
      CondCs: cond_pass = flag_c;
      CondCc: cond_pass = ~flag_c;
      CondMi: cond_pass = flag_n;
      CondPl: cond_pass = ~flag_n;
      CondVs: cond_pass = flag_v;
      CondVc: cond_pass = ~flag_v;
      CondHi: cond_pass = flag_c & ~flag_z;
      CondLs: cond_pass = ~flag_c | flag_z;
      CondGe: cond_pass = (flag_n == flag_v);
      CondLt: cond_pass = (flag_n != flag_v);
      CondGt: cond_pass = ~flag_z & (flag_n == flag_v);
      CondLe: cond_pass = flag_z | (flag_n != flag_v);
      CondAl: cond_pass = 1'b1;
      CondNv: begin
        cond_pass    = 1'b0;
        cond_illegal = 1'b1;
      end
      default: cond_pass = 1'b0;
    endcase
  end

  // An accepted instruction whose condition passed.
  assign exec = accept & cond_pass;

  // Flag update: N,Z and C,V are independently enabled, and only by an executing instruction.
  always_comb begin
    flags_d = flags_q;
    if (exec) begin
      if (flag_w_i[1]) begin
        flags_d[3:2] = alu_flags_i[3:2];
      end
      if (flag_w_i[0]) begin
        flags_d[1:0] = alu_flags_i[1:0];
      end
    end
  end

  // Output stage next state. A bubble (in_valid_i low) clears every strobe, so all strobes are
  // qualified by in_valid_i even though cond_pass alone would not be.
  always_comb begin
    out_valid_d = out_valid_q;
    cond_ex_d   = cond_ex_q;
    reg_write_d = reg_write_q;
    mem_write_d = mem_write_q;
    pc_src_d    = pc_src_q;
    illegal_d   = illegal_q;
    if (!stall_i) begin
      out_valid_d = in_valid_i;
      cond_ex_d   = in_valid_i & cond_pass;
      reg_write_d = in_valid_i & cond_pass & reg_w_i;
      mem_write_d = in_valid_i & cond_pass & mem_w_i;
      pc_src_d    = in_valid_i & cond_pass & pc_src_i;
      illegal_d   = in_valid_i & cond_illegal;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q     <= 4'b0000;
      out_valid_q <= 1'b0;
      cond_ex_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      pc_src_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      cond_ex_q   <= cond_ex_d;
      reg_write_q <= reg_write_d;
      mem_write_q <= mem_write_d;
      pc_src_q    <= pc_src_d;
      illegal_q   <= illegal_d;
    end
  end

  assign flags_o     = flags_q;
  assign out_valid_o = out_valid_q;
  assign cond_ex_o   = cond_ex_q;
  assign reg_write_o = reg_write_q;
  assign mem_write_o = mem_write_q;
  assign pc_src_o    = pc_src_q;
  assign illegal_o   = illegal_q;

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] exec_cnt_q,   exec_cnt_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    exec_cnt_d   = exec_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (accept) begin
      if (cond_pass) begin
        if (exec_cnt_q != {CNT_W{1'b1}}) begin
          exec_cnt_d = exec_cnt_q + CNT_W'(1);
        end
      end else begin
        if (squash_cnt_q != {CNT_W{1'b1}}) begin
          squash_cnt_d = squash_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exec_cnt_q   <= '0;
      squash_cnt_q <= '0;
    end else begin
      exec_cnt_q   <= exec_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign exec_cnt_o   = exec_cnt_q;
  assign squash_cnt_o = squash_cnt_q;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed vectors with literal expectations, plus a
// behavioural model compared against the DUT on every falling clock edge.
module tb_cond_unit;
  localparam int unsigned CNT_W = 16;

  logic       clk;
  logic       reset_n;
  logic       stall_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [3:0] cond_i;
  logic [3:0] alu_flags_i;
  logic [1:0] flag_w_i;
  logic       reg_w_i;
  logic       mem_w_i;
  logic       pc_src_i;
  logic       out_valid_o;
  logic       cond_ex_o;
  logic       reg_write_o;
  logic       mem_write_o;
  logic       pc_src_o;
  logic       illegal_o;
  logic [3:0] flags_o;
`ifdef COND_STATS_EN
  logic [CNT_W-1:0] exec_cnt_o;
  logic [CNT_W-1:0] squash_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall_i     (stall_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .cond_i      (cond_i),
    .alu_flags_i (alu_flags_i),
    .flag_w_i    (flag_w_i),
    .reg_w_i     (reg_w_i),
    .mem_w_i     (mem_w_i),
    .pc_src_i    (pc_src_i),
    .out_valid_o (out_valid_o),
    .cond_ex_o   (cond_ex_o),
    .reg_write_o (reg_write_o),
    .mem_write_o (mem_write_o),
    .pc_src_o    (pc_src_o),
    .illegal_o   (illegal_o),
    .flags_o     (flags_o)
`ifdef COND_STATS_EN
    ,
    .exec_cnt_o  (exec_cnt_o),
    .squash_cnt_o(squash_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Conditions come in complementary pairs: the even code is the base predicate and the odd
  // code its negation; E is always, F never.
  function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return c[0] ? !base : base;
  endfunction

  logic [3:0] m_flags;
  logic       m_valid, m_ce, m_rw, m_mw, m_ps, m_ill;
  logic       m_pass_now;
  int         m_exec, m_squash;
  localparam int CntMax = (1 << CNT_W) - 1;

  always_comb m_pass_now = model_pass(cond_i, m_flags);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_flags <= 4'h0;
      {m_valid, m_ce, m_rw, m_mw, m_ps, m_ill} <= '0;
      m_exec <= 0;
      m_squash <= 0;
    end else if (!stall_i) begin
      m_valid <= in_valid_i;
      m_ce    <= in_valid_i && m_pass_now;
      m_rw    <= in_valid_i && m_pass_now && reg_w_i;
      m_mw    <= in_valid_i && m_pass_now && mem_w_i;
      m_ps    <= in_valid_i && m_pass_now && pc_src_i;
      m_ill   <= in_valid_i && (cond_i == 4'hF);
      if (in_valid_i && m_pass_now) begin
        m_flags <= {flag_w_i[1] ? alu_flags_i[3:2] : m_flags[3:2],
                    flag_w_i[0] ? alu_flags_i[1:0] : m_flags[1:0]};
        if (m_exec < CntMax) m_exec <= m_exec + 1;
      end else if (in_valid_i) begin
        if (m_squash < CntMax) m_squash <= m_squash + 1;
      end
    end
  end

  // One compare per falling edge covering every output.
  always @(negedge clk) begin
    check("outputs", {in_ready_o, out_valid_o, cond_ex_o, reg_write_o, mem_write_o, pc_src_o,
                      illegal_o, flags_o},
                     {!stall_i, m_valid, m_ce, m_rw, m_mw, m_ps, m_ill, m_flags});
`ifdef COND_STATS_EN
    check("exec_cnt", exec_cnt_o, m_exec[CNT_W-1:0]);
    check("squash_cnt", squash_cnt_o, m_squash[CNT_W-1:0]);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic v, input logic [3:0] c, input logic [3:0] a,
                       input logic [1:0] fw, input logic rw, input logic mw, input logic ps,
                       input logic st);
    in_valid_i = v; cond_i = c; alu_flags_i = a; flag_w_i = fw;
    reg_w_i = rw; mem_w_i = mw; pc_src_i = ps; stall_i = st;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    {in_valid_i, cond_i, alu_flags_i, flag_w_i, reg_w_i, mem_w_i, pc_src_i, stall_i} = '0;
    do_reset();
    check("reset_flags", flags_o, 4'h0);
    check("reset_valid", out_valid_o, 1'b0);

    // AL with full flag write.
    issue(1, 4'hE, 4'b0100, 2'b11, 1, 0, 0, 0);
    check("al_reg_write", reg_write_o, 1'b1);
    check("al_flags", flags_o, 4'b0100);

    // EQ passes with Z=1, NE squashed.
    issue(1, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0);
    check("eq_mem_write", mem_write_o, 1'b1);
    issue(1, 4'h1, 4'h0, 2'b00, 0, 1, 0, 0);
    check("ne_mem_write", mem_write_o, 1'b0);
    check("ne_out_valid", out_valid_o, 1'b1);
    check("ne_cond_ex", cond_ex_o, 1'b0);

    // Squashed instruction leaves flags alone.
    issue(1, 4'hE, 4'b0000, 2'b11, 0, 0, 0, 0);
    issue(1, 4'h0, 4'b1000, 2'b11, 0, 0, 0, 0);
    check("squash_flags", flags_o, 4'b0000);
    issue(1, 4'hE, 4'b1000, 2'b11, 0, 0, 0, 0);
    check("exec_flags", flags_o, 4'b1000);

    // Partial update of N,Z only.
    issue(1, 4'hE, 4'b1111, 2'b11, 0, 0, 0, 0);
    issue(1, 4'hE, 4'b0000, 2'b10, 0, 0, 0, 0);
    check("partial_flags", flags_o, 4'b0011);

    // Signed conditions with N=1,V=0.
    issue(1, 4'hE, 4'b1000, 2'b11, 0, 0, 0, 0);
    issue(1, 4'hA, 4'h0, 2'b00, 0, 0, 0, 0);
    check("ge", cond_ex_o, 1'b0);
    issue(1, 4'hB, 4'h0, 2'b00, 0, 0, 0, 0);
    check("lt", cond_ex_o, 1'b1);
    issue(1, 4'hD, 4'h0, 2'b00, 0, 0, 0, 0);
    check("le", cond_ex_o, 1'b1);
    issue(1, 4'hC, 4'h0, 2'b00, 0, 0, 0, 0);
    check("gt", cond_ex_o, 1'b0);

    // Unsigned conditions with C=1,Z=0.
    issue(1, 4'hE, 4'b0010, 2'b11, 0, 0, 0, 0);
    issue(1, 4'h8, 4'h0, 2'b00, 0, 0, 0, 0);
    check("hi", cond_ex_o, 1'b1);
    issue(1, 4'h9, 4'h0, 2'b00, 0, 0, 0, 0);
    check("ls", cond_ex_o, 1'b0);

    // Branch + register write, then stall for 3 cycles.
    issue(1, 4'hE, 4'h0, 2'b00, 1, 0, 1, 0);
    check("pc_src", pc_src_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      issue(1, 4'hE, 4'b1111, 2'b11, 0, 1, 0, 1);
      check("stall_reg_write", reg_write_o, 1'b1);
      check("stall_mem_write", mem_write_o, 1'b0);
      check("stall_flags", flags_o, 4'b0010);
      check("stall_ready", in_ready_o, 1'b0);
    end

    // Illegal condition.
    issue(1, 4'hF, 4'b1111, 2'b11, 1, 1, 1, 0);
    check("illegal", illegal_o, 1'b1);
    check("illegal_reg_write", reg_write_o, 1'b0);
    check("illegal_valid", out_valid_o, 1'b1);
    check("illegal_flags", flags_o, 4'b0010);

    // Bubble.
    issue(0, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0);
    check("bubble_valid", out_valid_o, 1'b0);
    check("bubble_reg_write", reg_write_o, 1'b0);
    check("bubble_flags", flags_o, 4'b0010);

    // Sweep every condition against every flag pattern; the model checks each cycle.
    for (int f = 0; f < 16; f++) begin
      issue(1, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0);
      for (int c = 0; c < 16; c++) begin
        issue(1, 4'(c), ~4'(f), 2'(c), 1, 1, 1, 0);
      end
    end

    // Asynchronous reset mid-cycle while outputs are active.
    issue(1, 4'hE, 4'b0110, 2'b11, 1, 1, 1, 0);
    check("pre_reset_valid", out_valid_o, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_valid", out_valid_o, 1'b0);
    check("async_reset_reg_write", reg_write_o, 1'b0);
    check("async_reset_flags", flags_o, 4'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    issue(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    check("post_reset_valid", out_valid_o, 1'b0);

`ifdef COND_STATS_EN
    do_reset();
    in_valid_i = 1; cond_i = 4'hE; flag_w_i = 2'b00; stall_i = 0;
    repeat (70000) @(posedge clk);
    #1;
    check("exec_sat", exec_cnt_o, 16'hFFFF);
    check("squash_zero", squash_cnt_o, 16'h0000);
`endif

    in_valid_i = 0;
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
